// File: rtl/countdown_timer_mmss_pkg.sv
// Shared types and BCD helpers for the MM:SS countdown timer.
package countdown_timer_mmss_pkg;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_RUN,
        ST_PAUSE,
        ST_DONE
    } state_e;

    localparam logic [3:0] BCD_MAX = 4'd9;

    // Clamp a raw nibble into the legal BCD range.
    function automatic logic [3:0] bcd_clamp(input logic [3:0] digit);
        return (digit > BCD_MAX) ? BCD_MAX : digit;
    endfunction

    // Increment one BCD digit by carry-in; returns {carry_out, digit}.
    function automatic logic [4:0] bcd_inc(input logic [3:0] digit, input logic cin);
        logic [4:0] res;
        if (!cin) begin
            res = {1'b0, digit};
        end else if (digit >= BCD_MAX) begin
            res = {1'b1, 4'd0};
        end else begin
            res = {1'b0, digit + 4'd1};
        end
        return res;
    endfunction

endpackage

// File: rtl/countdown_timer_mmss_bcd_down_digit.sv
// One BCD down-counting digit with parallel load and borrow chaining.
module countdown_timer_mmss_bcd_down_digit #(
    parameter int MOD = 10
) (
    input  logic       clk,
    input  logic       clearn,
    input  logic [3:0] load_val,
    input  logic       load_en,
    input  logic       dec_en,
    input  logic       borrow_in,
    output logic [3:0] digit,
    output logic       borrow_out,
    output logic       is_zero
);

    localparam logic [3:0] DIGIT_TOP = 4'(MOD - 1);

    logic [3:0] digit_d;
    logic [3:0] digit_q;

    // Next digit value: load wins over decrement; decrement wraps to DIGIT_TOP.
    always_comb begin
        // NOTE: default assignment first so no path leaves digit_d unassigned (no latch).
        digit_d = digit_q;
        if (load_en) begin
            digit_d = load_val;
        end else if (dec_en && borrow_in) begin
            digit_d = (digit_q == 4'd0) ? DIGIT_TOP : digit_q - 4'd1;
        end
    end

    // Digit register, cleared asynchronously.
    always_ff @(posedge clk or negedge clearn) begin
        if (!clearn) begin
            digit_q <= 4'd0;
        end else begin
            // NOTE: non-blocking assignment so all flops update together at the edge.
            digit_q <= digit_d;
        end
    end

    assign digit      = digit_q;
    assign is_zero    = (digit_q == 4'd0);
    assign borrow_out = dec_en & borrow_in & is_zero;

endmodule

// File: rtl/countdown_timer_mmss.sv
// MM:SS BCD countdown with load normalisation and start/pause/stop control.
module countdown_timer_mmss
    import countdown_timer_mmss_pkg::*;
#(
    parameter int MIN_DIGITS   = 2,
    parameter int SEC_TENS_MOD = 6,
    parameter bit NORMALISE    = 1'b1
) (
    input  logic                    clk,
    input  logic                    clearn,
    input  logic                    loadn,
    input  logic [7:0]              data_sec,
    input  logic [4*MIN_DIGITS-1:0] data_min,
    input  logic                    start,
    input  logic                    pause,
    input  logic                    stop,
    input  logic                    tick,
    output logic [3:0]              sec_ones,
    output logic [3:0]              sec_tens,
    output logic [4*MIN_DIGITS-1:0] minutes,
    output logic                    zero,
    output logic                    done,
    output logic                    running,
    output logic                    carry_out
);

    localparam int         ND       = 2 + MIN_DIGITS;
    localparam logic [3:0] TENS_MAX = 4'(SEC_TENS_MOD - 1);

    state_e state_q, state_d;
    logic   done_q, done_d;
    logic   running_q, running_d;
    logic   carry_q, carry_d;

    logic [ND-1:0][3:0] digits;
    logic [ND-1:0][3:0] load_val;
    logic [ND-1:0]      is_zero;
    logic               msd_borrow;

    logic load_req, load_ok, dec_en, last_second, dig_load_en, dig_clear;
    logic [3:0] s_ones, s_tens;
    logic [MIN_DIGITS-1:0][3:0] s_min;
    logic load_carry, all_nines, inc_c;

    assign load_req    = !loadn;
    assign load_ok     = !stop && load_req && (state_q != ST_RUN);
    assign dec_en      = (state_q == ST_RUN) && tick && !stop && !pause;
    assign zero        = &is_zero;
    assign last_second = (digits[0] == 4'd1) && (&is_zero[ND-1:1]);
    // A borrow escaping the top digit means the count is already 00:00; reload zero to hold.
    assign dig_clear   = stop || msd_borrow;
    assign dig_load_en = dig_clear || load_ok;

    // Sanitise the entered value: clamp digits, then fold or clamp the seconds tens.
    always_comb begin
        s_ones     = bcd_clamp(data_sec[3:0]);
        s_tens     = bcd_clamp(data_sec[7:4]);
        all_nines  = 1'b1;
        load_carry = 1'b0;
        inc_c      = 1'b1;
        for (int i = 0; i < MIN_DIGITS; i++) begin
            s_min[i]  = bcd_clamp(data_min[4*i +: 4]);
            all_nines = all_nines && (s_min[i] == BCD_MAX);
        end
        if (s_tens > TENS_MAX) begin
            load_carry = 1'b1;
            if (!NORMALISE) begin
                s_tens = TENS_MAX;
            end else if (all_nines) begin
                s_tens = TENS_MAX;
                s_ones = BCD_MAX;
            end else begin
                s_tens = s_tens - 4'(SEC_TENS_MOD);
                for (int i = 0; i < MIN_DIGITS; i++) begin
                    {inc_c, s_min[i]} = bcd_inc(s_min[i], inc_c);
                end
            end
        end
        load_val = dig_clear ? '0 : {s_min, s_tens, s_ones};
    end

    // Digit chain: index 0 = seconds ones, 1 = seconds tens, 2.. = minutes LS first.
    for (genvar i = 0; i < ND; i++) begin : g_digit
        localparam int M = (i == 1) ? SEC_TENS_MOD : 10;
        logic bin;
        logic bout;
        if (i == 0) begin : g_lsd
            assign bin = 1'b1;
        end else begin : g_chain
            assign bin = g_digit[i-1].bout;
        end
        countdown_timer_mmss_bcd_down_digit #(.MOD(M)) u_digit (
            .clk        (clk),
            .clearn     (clearn),
            .load_val   (load_val[i]),
            .load_en    (dig_load_en),
            .dec_en     (dec_en),
            .borrow_in  (bin),
            .digit      (digits[i]),
            .borrow_out (bout),
            .is_zero    (is_zero[i])
        );
    end

    assign msd_borrow = g_digit[ND-1].bout;

    // Control next-state: stop overrides everything, load beats pause beats start beats tick.
    always_comb begin
        state_d = state_q;
        done_d  = 1'b0;
        carry_d = carry_q;
        if (stop) begin
            state_d = ST_IDLE;
        end else begin
            case (state_q)
                ST_IDLE:  if (!load_req && start && !zero) state_d = ST_RUN;
                ST_RUN: begin
                    if (pause) begin
                        state_d = ST_PAUSE;
                    end else if (tick && last_second) begin
                        state_d = ST_DONE;
                        done_d  = 1'b1;
                    end
                end
                ST_PAUSE: if (!load_req && start && !zero) state_d = ST_RUN;
                ST_DONE:  if (load_req || start) state_d = ST_IDLE;
                default:  state_d = ST_IDLE;
            endcase
            if (load_ok) carry_d = load_carry;
        end
        running_d = (state_d == ST_RUN);
    end

    // Control FSM and registered status outputs.
    always_ff @(posedge clk or negedge clearn) begin
        if (!clearn) begin
            state_q   <= ST_IDLE;
            done_q    <= 1'b0;
            running_q <= 1'b0;
            carry_q   <= 1'b0;
        end else begin
            state_q   <= state_d;
            done_q    <= done_d;
            running_q <= running_d;
            carry_q   <= carry_d;
        end
    end

    assign sec_ones  = digits[0];
    assign sec_tens  = digits[1];
    assign minutes   = digits[ND-1:2];
    assign done      = done_q;
    assign running   = running_q;
    assign carry_out = carry_q;

endmodule

// File: tb/tb_countdown_timer_mmss.sv
// Directed bench for countdown_timer_mmss (MIN_DIGITS=2, SEC_TENS_MOD=6, NORMALISE=1).
module tb_countdown_timer_mmss;

    logic       clk = 1'b0;
    logic       clearn = 1'b0;
    logic       loadn = 1'b1;
    logic [7:0] data_sec = 8'h00;
    logic [7:0] data_min = 8'h00;
    logic       start = 1'b0;
    logic       pause = 1'b0;
    logic       stop = 1'b0;
    logic       tick = 1'b0;
    logic [3:0] sec_ones, sec_tens;
    logic [7:0] minutes;
    logic       zero, done, running, carry_out;

    int n_checks = 0;
    int n_fail   = 0;

    // Display as MMSS hex and flags as {running, done, zero, carry_out}.
    wire [15:0] disp  = {minutes, sec_tens, sec_ones};
    wire [3:0]  flags = {running, done, zero, carry_out};

    countdown_timer_mmss #(
        .MIN_DIGITS   (2),
        .SEC_TENS_MOD (6),
        .NORMALISE    (1'b1)
    ) dut (
        .clk       (clk),
        .clearn    (clearn),
        .loadn     (loadn),
        .data_sec  (data_sec),
        .data_min  (data_min),
        .start     (start),
        .pause     (pause),
        .stop      (stop),
        .tick      (tick),
        .sec_ones  (sec_ones),
        .sec_tens  (sec_tens),
        .minutes   (minutes),
        .zero      (zero),
        .done      (done),
        .running   (running),
        .carry_out (carry_out)
    );

    always #5 clk = ~clk;

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic do_load(input logic [7:0] s, input logic [7:0] m);
        data_sec = s;
        data_min = m;
        loadn    = 1'b0;
        cyc();
        loadn    = 1'b1;
    endtask

    task automatic do_start();
        start = 1'b1;
        cyc();
        start = 1'b0;
    endtask

    task automatic do_tick();
        tick = 1'b1;
        cyc();
        tick = 1'b0;
    endtask

    task automatic do_stop();
        stop = 1'b1;
        cyc();
        stop = 1'b0;
    endtask

    task automatic test_reset();
        #12;
        n_checks++; if (disp !== 16'h0000) begin n_fail++; $display("FAIL reset_value: got %h want %h", disp, 16'h0000); end
        n_checks++; if (flags !== 4'b0010) begin n_fail++; $display("FAIL reset_flags: got %b want %b", flags, 4'b0010); end
        @(posedge clk);
        #1 clearn = 1'b1;
        cyc();
    endtask

    task automatic test_count();
        do_load(8'h45, 8'h07);
        n_checks++; if (disp !== 16'h0745) begin n_fail++; $display("FAIL count_load: got %h want %h", disp, 16'h0745); end
        do_start();
        n_checks++; if (flags !== 4'b1000) begin n_fail++; $display("FAIL count_start_flags: got %b want %b", flags, 4'b1000); end
        tick = 1'b1;
        repeat (45) cyc();
        n_checks++; if (disp !== 16'h0700) begin n_fail++; $display("FAIL count_45: got %h want %h", disp, 16'h0700); end
        cyc();
        tick = 1'b0;
        n_checks++; if (disp !== 16'h0659) begin n_fail++; $display("FAIL count_46: got %h want %h", disp, 16'h0659); end
        n_checks++; if (flags !== 4'b1000) begin n_fail++; $display("FAIL count_46_flags: got %b want %b", flags, 4'b1000); end
        do_stop();
    endtask

    task automatic test_normalise();
        do_load(8'h75, 8'h03);
        n_checks++; if ({disp, carry_out} !== {16'h0415, 1'b1}) begin n_fail++; $display("FAIL norm_0375: got %h/%b want 0415/1", disp, carry_out); end
        do_load(8'h75, 8'h99);
        n_checks++; if ({disp, carry_out} !== {16'h9959, 1'b1}) begin n_fail++; $display("FAIL norm_sat: got %h/%b want 9959/1", disp, carry_out); end
        do_load(8'h30, 8'h00);
        n_checks++; if ({disp, carry_out} !== {16'h0030, 1'b0}) begin n_fail++; $display("FAIL norm_plain: got %h/%b want 0030/0", disp, carry_out); end
        do_load(8'hAF, 8'h0B);
        n_checks++; if ({disp, carry_out} !== {16'h1039, 1'b1}) begin n_fail++; $display("FAIL norm_clamp: got %h/%b want 1039/1", disp, carry_out); end
        do_stop();
        n_checks++; if (flags !== 4'b0011) begin n_fail++; $display("FAIL norm_carry_held: got %b want %b", flags, 4'b0011); end
    endtask

    task automatic test_done();
        do_load(8'h02, 8'h00);
        do_start();
        do_tick();
        n_checks++; if ({disp, flags} !== {16'h0001, 4'b1000}) begin n_fail++; $display("FAIL done_t1: got %h/%b want 0001/1000", disp, flags); end
        do_tick();
        n_checks++; if ({disp, flags} !== {16'h0000, 4'b0110}) begin n_fail++; $display("FAIL done_t2: got %h/%b want 0000/0110", disp, flags); end
        cyc();
        n_checks++; if (flags !== 4'b0010) begin n_fail++; $display("FAIL done_pulse_width: got %b want %b", flags, 4'b0010); end
        do_tick();
        n_checks++; if ({disp, flags} !== {16'h0000, 4'b0010}) begin n_fail++; $display("FAIL done_hold: got %h/%b want 0000/0010", disp, flags); end
        do_start();
        do_start();
        n_checks++; if (flags !== 4'b0010) begin n_fail++; $display("FAIL done_restart_zero: got %b want %b", flags, 4'b0010); end
    endtask

    task automatic test_pause();
        do_load(8'h00, 8'h01);
        do_start();
        pause = 1'b1;
        tick  = 1'b1;
        cyc();
        pause = 1'b0;
        tick  = 1'b0;
        n_checks++; if ({disp, flags} !== {16'h0100, 4'b0000}) begin n_fail++; $display("FAIL pause_tick: got %h/%b want 0100/0000", disp, flags); end
        do_tick();
        n_checks++; if (disp !== 16'h0100) begin n_fail++; $display("FAIL pause_no_dec: got %h want %h", disp, 16'h0100); end
        do_load(8'h30, 8'h02);
        n_checks++; if ({disp, flags} !== {16'h0230, 4'b0000}) begin n_fail++; $display("FAIL pause_load: got %h/%b want 0230/0000", disp, flags); end
        do_start();
        n_checks++; if (flags !== 4'b1000) begin n_fail++; $display("FAIL pause_resume: got %b want %b", flags, 4'b1000); end
        do_tick();
        n_checks++; if (disp !== 16'h0229) begin n_fail++; $display("FAIL pause_borrow: got %h want %h", disp, 16'h0229); end
        do_stop();
    endtask

    task automatic test_stop();
        do_load(8'h34, 8'h12);
        do_start();
        n_checks++; if ({disp, flags} !== {16'h1234, 4'b1000}) begin n_fail++; $display("FAIL stop_run: got %h/%b want 1234/1000", disp, flags); end
        stop     = 1'b1;
        loadn    = 1'b0;
        data_sec = 8'h59;
        data_min = 8'h45;
        cyc();
        stop     = 1'b0;
        loadn    = 1'b1;
        n_checks++; if ({disp, flags} !== {16'h0000, 4'b0010}) begin n_fail++; $display("FAIL stop_over_load: got %h/%b want 0000/0010", disp, flags); end
        do_start();
        n_checks++; if (flags !== 4'b0010) begin n_fail++; $display("FAIL stop_start_zero: got %b want %b", flags, 4'b0010); end
    endtask

    task automatic test_async_reset();
        do_load(8'h75, 8'h04);
        do_start();
        do_tick();
        n_checks++; if ({disp, flags} !== {16'h0514, 4'b1001}) begin n_fail++; $display("FAIL arst_pre: got %h/%b want 0514/1001", disp, flags); end
        #3 clearn = 1'b0;
        #1;
        n_checks++; if ({disp, flags} !== {16'h0000, 4'b0010}) begin n_fail++; $display("FAIL arst_async: got %h/%b want 0000/0010", disp, flags); end
        #2 clearn = 1'b1;
        cyc();
        do_start();
        n_checks++; if (flags !== 4'b0010) begin n_fail++; $display("FAIL arst_start_noload: got %b want %b", flags, 4'b0010); end
    endtask

    initial begin
        test_reset();
        test_count();
        test_normalise();
        test_done();
        test_pause();
        test_stop();
        test_async_reset();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
